// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU control codes, FSM encoding, latched request struct.
package alu_arbiter_pkg;
  localparam int NUM_REQ = 2;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_MUL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  ctrl;
  } alu_req_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter; slave = arbiter side, master = requesters/consumer.
interface alu_arbiter_if;
  logic        req0_valid_i, req0_ready_o;
  logic [31:0] req0_data1_i, req0_data2_i;
  logic [2:0]  req0_ctrl_i;
  logic        req1_valid_i, req1_ready_o;
  logic [31:0] req1_data1_i, req1_data2_i;
  logic [2:0]  req1_ctrl_i;
  logic        resp_valid_o, resp_ready_i, resp_id_o, resp_zero_o, busy_o;
  logic [31:0] resp_data_o;

  modport slave (
    input  req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    input  req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    input  resp_ready_i,
    output req0_ready_o, req1_ready_o,
    output resp_valid_o, resp_id_o, resp_data_o, resp_zero_o, busy_o
  );

  modport master (
    output req0_valid_i, req0_data1_i, req0_data2_i, req0_ctrl_i,
    output req1_valid_i, req1_data1_i, req1_data2_i, req1_ctrl_i,
    output resp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  resp_valid_o, resp_id_o, resp_data_o, resp_zero_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unlisted control codes yield 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  ctrl_i,
  output logic [31:0] y_o
);
  always_comb begin
    y_o = '0;
    case (ctrl_i)
      CTRL_AND: y_o = a_i & b_i;
      CTRL_OR:  y_o = a_i | b_i;
      CTRL_ADD: y_o = a_i + b_i;
      CTRL_SUB: y_o = a_i - b_i;
      CTRL_MUL: y_o = a_i * b_i;
      default:  y_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: arbitrate, latch, run 1 or MUL_CYCLES cycles, respond.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  alu_arbiter_if.slave bus
);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic     [NUM_REQ-1:0] req_vld;
  alu_req_t [NUM_REQ-1:0] req_op;

  assign req_vld   = {bus.req1_valid_i, bus.req0_valid_i};
  assign req_op[0] = '{data1: bus.req0_data1_i, data2: bus.req0_data2_i, ctrl: bus.req0_ctrl_i};
  assign req_op[1] = '{data1: bus.req1_data1_i, data2: bus.req1_data2_i, ctrl: bus.req1_ctrl_i};

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  alu_req_t    op_q, op_d;
  logic        id_q, id_d;
  logic        resp_id_q, resp_id_d;
  logic        resp_zero_q, resp_zero_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [31:0] alu_y;
  logic        grant, accept;

  // Ready is only raised toward a requester that is actually presenting work.
  assign accept = (state_q == IDLE) && |req_vld;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    grant  = (&req_vld) ? ~last_q : req_vld[1];
    last_d = accept ? grant : last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign grant = ~req_vld[0] & req_vld[1];
`endif

  alu_arbiter_alu u_alu (
    .a_i   (op_q.data1),
    .b_i   (op_q.data2),
    .ctrl_i(op_q.ctrl),
    .y_o   (alu_y)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    id_d        = id_q;
    resp_id_d   = resp_id_q;
    resp_zero_d = resp_zero_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = req_op[grant];
        id_d    = grant;
        cnt_d   = (req_op[grant].ctrl == CTRL_MUL) ? CW'(MUL_CYCLES) : CW'(1);
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          resp_data_d = alu_y;
          resp_zero_d = (alu_y == 32'd0);
          resp_id_d   = id_q;
          state_d     = RESP;
        end
      end
      RESP: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_zero_q <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      resp_id_q   <= resp_id_d;
      resp_zero_q <= resp_zero_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req0_ready_o = accept && !grant;
  assign bus.req1_ready_o = accept && grant;
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_id_o    = resp_id_q;
  assign bus.resp_data_o  = resp_data_q;
  assign bus.resp_zero_o  = resp_zero_q;
  assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single ALU instance between two requesters (e.g. integer pipe and address/debug port) with valid/ready handshakes. Arbitrates, latches operands, sequences the ALU over a multi-cycle execute phase when the operation is multiply, and returns result plus zero flag on one shared, ID-tagged response channel. It sits between the requesters and the ALU; the ALU itself is untouched.

## Interface
- MUL_CYCLES, 4, execute cycles for multiply (ctrl 3'b011); legal range 1..15
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 accepted this cycle
- req0_data1_i / req0_data2_i  in  32  operands, requester 0
- req0_ctrl_i  in  3  ALU control, requester 0 (000 AND, 001 OR, 010 ADD, 110 SUB, 011 MUL)
- req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i  same for requester 1
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  consumer takes result
- resp_id_o  out  1  requester that owns the result
- resp_data_o  out  32  ALU result
- resp_zero_o  out  1  result == 0
- busy_o  out  1  state != IDLE

## Operation
- FSM states IDLE, EXEC, RESP; reset state IDLE.
- IDLE: if any reqN_valid_i, grant one requester. reqN_ready_o = (state==IDLE) && grant==N, combinational. On handshake, latch operands, ctrl and id. Go to EXEC, load count = MUL_CYCLES if ctrl==011, else 1.
- EXEC: latched operands drive the ALU continuously. Decrement count each cycle. When count==1, register ALU result and zero flag into the response registers and go to RESP.
- RESP: resp_valid_o=1. resp_id_o/data/zero stay stable until resp_valid_o && resp_ready_i; then go to IDLE. No new request is accepted in the same cycle as the response handshake.
- Arithmetic: 32-bit wraparound. MUL returns the low 32 bits of the product. Unlisted ctrl codes give result 0 and zero 1, with a 1-cycle execute.
- Only one transaction is in flight. Both ready outputs are low outside IDLE.
- Requester inputs are sampled only on the handshake cycle. Later changes do not affect the transaction in flight.

## Timing
- Accept in cycle N; resp_valid_o rises in cycle N+L+1. L=1 for non-MUL, L=MUL_CYCLES for MUL.
- Minimum turnaround with resp_ready_i held high: one accept every L+2 cycles.
- Reset values: req0/1_ready_o 0, resp_valid_o 0, resp_id_o 0, resp_data_o 0, resp_zero_o 0, busy_o 0, count 0, last-grant register 1.
- Reset asserted mid-EXEC or mid-RESP: immediate return to IDLE and the transaction is dropped. No response is produced after deassertion.
- Simultaneous valid on both requesters: arbitration per Configuration. Grant is decided combinationally from the current-cycle valids.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration. On contention, grant the requester not recorded in the last-grant register. That register updates on every accept. After reset, requester 0 wins the first contention.
- ALU_ARB_RR_EN undefined: fixed priority; requester 0 always wins contention. The last-grant register is not built.

## Structure
- Shared package holds the ALU control localparams (CTRL_AND 3'b000, CTRL_OR 3'b001, CTRL_ADD 3'b010, CTRL_SUB 3'b110, CTRL_MUL 3'b011) and the FSM state encoding (IDLE 2'd0, EXEC 2'd1, RESP 2'd2).
- One sub-module: the team's existing ALU module, instantiated once and fed from the latched operand registers. The arbiter uses only its data output and computes resp_zero_o itself from the registered result.
- Counter width is $clog2(MUL_CYCLES+1).

## Test plan
- Requester 0 sends ADD 5+7, resp_ready_i held 1 -> resp_valid_o 2 cycles after accept with data 12, zero 0, id 0.
- Requester 1 sends MUL 0x10000*0x10001, MUL_CYCLES=4 -> response 5 cycles after accept with data 0x00010000 (low 32 bits), id 1. busy_o is high throughout.
- Requester 0 sends SUB 9-9 -> data 0, zero 1. Hold resp_ready_i low 3 cycles -> outputs stable and both ready outputs low until the response handshake.
- Both requesters valid continuously, 4 ops each -> with ALU_ARB_RR_EN the grant order is 0,1,0,1,…; without it, all of requester 0 goes first.
- Assert rst_i during EXEC of a MUL -> all outputs return to their reset values asynchronously, and no response appears after release.
- Requester 1 sends ctrl 3'b111 with arbitrary operands -> data 0, zero 1, 1-cycle execute.
